// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I encoding constants, field-format enum, NOP word
//               and the encoder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Major opcodes for the formats the encoder can emit.
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Canonical NOP: addi x0, x0, 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Field-bundle format selector as presented on in_fmt.
    typedef enum logic [1:0] {
        FMT_IALU  = 2'd0,
        FMT_LOAD  = 2'd1,
        FMT_STORE = 2'd2,
        FMT_RSVD  = 2'd3
    } fmt_e;

    // Run-control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True when a sign-extended 32-bit value is representable in a signed
    // 12-bit field, i.e. bits 31:11 are all copies of the sign.
    function automatic logic imm_fits_s12(input logic [31:0] imm);
        return (&imm[31:11]) | ~(|imm[31:11]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational field-to-word packer for the I-ALU, LOAD and
//               STORE formats. Raises reject for the reserved format and,
//               when IMM_RANGE_CHECK_EN is defined, for immediates outside
//               the signed 12-bit range; rejected bundles pack to NOP.
// Config      : IMM_RANGE_CHECK_EN (optional immediate range check)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack (
    input  logic [1:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        reject
);
    import riscv_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    fmt_e w_fmt;
    logic w_out_of_range;

    // Classify the bundle, then build the word; rejects fall back to NOP so
    // the address stream stays dense.
    always_comb begin
        w_fmt          = fmt_e'(fmt);
        w_out_of_range = RANGE_CHECK && !imm_fits_s12(imm);
        reject         = (w_fmt == FMT_RSVD) || w_out_of_range;
        instr          = NOP_INSTR;
        if (!reject) begin
            case (w_fmt)
                FMT_IALU:  instr = {imm[11:0], rs1, funct3, rd, OP_IMM};
                FMT_LOAD:  instr = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                FMT_STORE: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                default:   instr = NOP_INSTR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Accepts decoded RV32I field bundles over a valid/ready
//               handshake and emits one registered instruction word plus its
//               word address per bundle. Tracks a program run from start to
//               the word flagged last, with sticky reject reporting.
// Config      : IMM_RANGE_CHECK_EN (passed through to instr_pack)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int               ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err
);
    import riscv_pkg::*;

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;
    logic              r_done;
    logic              r_err;

    logic [31:0]       w_pack_instr;
    logic              w_pack_reject;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_xfer;

    instr_pack u_pack (
        .fmt    (in_fmt),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .imm    (in_imm),
        .instr  (w_pack_instr),
        .reject (w_pack_reject)
    );

    // Pass-through handshake: a new bundle may enter whenever the output
    // slot is empty or is being drained this cycle; start always wins.
    always_comb begin
        w_in_ready = (r_state == ST_RUN) && !start && (!r_out_valid || out_ready);
        w_accept   = in_valid && w_in_ready;
        w_xfer     = r_out_valid && out_ready;
    end

    // Run FSM, address counter and one-entry output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr_cnt  <= BASE_ADDR;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= BASE_ADDR;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (start) begin
            // Restart from any state; a pending word is discarded, although
            // a word handshaking in this same cycle has already left.
            r_state     <= ST_RUN;
            r_addr_cnt  <= BASE_ADDR;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_pack_instr;
                r_out_addr  <= r_addr_cnt;
                r_out_last  <= in_last;
                r_addr_cnt  <= r_addr_cnt + 1'b1;
                if (w_pack_reject) begin
                    r_err <= 1'b1;
                end
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    // The run ends once the word flagged last has been taken.
                    if (w_xfer && r_out_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE only leave on start.
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder (ADDR_W = 4) with a
//               behavioural scoreboard of expected words and addresses.
// Config      : IMM_RANGE_CHECK_EN (must match the RTL build)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int AW = 4;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_fmt;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [31:0]   in_imm;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W    (AW),
        .BASE_ADDR ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [31:0] instr;
        int          addr;
        bit          last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_run;
    bit   m_done;
    bit   m_err;
    int   m_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Reference encoder: built from the field layout with plain arithmetic.
    function automatic logic [31:0] ref_word(input logic [1:0] fmt, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic [31:0] imm,
                                             output bit rej);
        int          simm;
        logic [31:0] lo;
        simm = $signed(imm);
        rej  = (fmt == 2'd3) || (RC && (simm < -2048 || simm > 2047));
        lo   = imm % 32'd4096;
        if (rej)
            return 32'h0000_0013;
        if (fmt == 2'd2)
            return (lo / 32'd32) * 32'd33554432 + 32'(rs2) * 32'd1048576 + 32'(rs1) * 32'd32768
                   + 32'(f3) * 32'd4096 + (lo % 32'd32) * 32'd128 + 32'h23;
        return lo * 32'd1048576 + 32'(rs1) * 32'd32768 + 32'(f3) * 32'd4096
               + 32'(rd) * 32'd128 + ((fmt == 2'd0) ? 32'h13 : 32'h03);
    endfunction

    task automatic model_reset();
        q.delete();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_addr = 0;
    endtask

    // One clock: check handshake/transfer before the edge, advance the
    // model after it, then check status outputs.
    task automatic cycle();
        bit   rdy_e;
        bit   acc;
        bit   xfer;
        bit   rej;
        exp_t e;
        rdy_e = 1'b0;
        #1;
        if (!rst) begin
            rdy_e = m_run && !start && (q.size() == 0 || out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_e});
        end
        xfer = !rst && q.size() > 0 && out_ready;
        if (xfer) begin
            chk("xfer_instr", out_instr, q[0].instr);
            chk("xfer_addr", 32'(out_addr), 32'(q[0].addr));
        end
        acc = !rst && in_valid && rdy_e;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (start) begin
            q.delete();
            m_run  = 1'b1;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_addr = 0;
        end else begin
            if (xfer) begin
                if (q[0].last) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
                void'(q.pop_front());
            end
            if (acc) begin
                e.instr = ref_word(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, rej);
                e.addr  = m_addr;
                e.last  = in_last;
                q.push_back(e);
                m_addr = (m_addr + 1) % (1 << AW);
                if (rej)
                    m_err = 1'b1;
            end
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic set_bundle(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                              input bit last);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
        in_last   = last;
    endtask

    task automatic set_random(input bit allow_rsvd);
        logic [31:0] imm;
        case ($urandom % 4)
            0:       imm = 32'($signed(12'($urandom)));
            1: begin
                case ($urandom % 4)
                    0:       imm = 32'd2047;
                    1:       imm = 32'hFFFF_F800;
                    2:       imm = 32'd2048;
                    default: imm = 32'hFFFF_F7FF;
                endcase
            end
            2:       imm = 32'($urandom % 64);
            default: imm = $urandom;
        endcase
        set_bundle(allow_rsvd ? 2'($urandom) : 2'($urandom % 3), 5'($urandom), 5'($urandom),
                   5'($urandom), 3'($urandom), imm, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    logic [31:0] snap_instr;
    logic [31:0] snap_addr;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = 2'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_imm    = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state; a bundle offered in IDLE is ignored.
        set_bundle(2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 32'd5, 1'b0);
        cycle();
        cycle();
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", 32'(out_addr), 32'h0);
        in_valid = 1'b0;

        // Field encoding, back-to-back.
        pulse_start();
        set_bundle(2'd0, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b0);
        cycle();
        chk("enc_ialu", out_instr, 32'hFFF1_0093);
        chk("enc_ialu_addr", 32'(out_addr), 32'd0);
        set_bundle(2'd1, 5'd5, 5'd6, 5'd0, 3'd2, 32'd8, 1'b0);
        cycle();
        chk("enc_load", out_instr, 32'h0083_2283);
        chk("enc_load_addr", 32'(out_addr), 32'd1);
        set_bundle(2'd2, 5'd0, 5'd8, 5'd7, 3'd2, 32'd20, 1'b0);
        cycle();
        chk("enc_store", out_instr, 32'h0074_2A23);
        chk("enc_store_addr", 32'(out_addr), 32'd2);
        in_valid = 1'b0;
        cycle();

        // Backpressure: word held stable, nothing accepted, then resume.
        set_bundle(2'd0, 5'd3, 5'd4, 5'd0, 3'd7, 32'hFFFF_FFFB, 1'b0);
        cycle();
        out_ready = 1'b0;
        set_bundle(2'd1, 5'd9, 5'd10, 5'd0, 3'd1, 32'd100, 1'b0);
        snap_instr = out_instr;
        snap_addr  = 32'(out_addr);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_instr", out_instr, snap_instr);
            chk("bp_hold_addr", 32'(out_addr), snap_addr);
        end
        out_ready = 1'b1;
        cycle();
        set_bundle(2'd2, 5'd0, 5'd11, 5'd12, 3'd0, 32'hFFFF_FFE0, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Reject paths.
        set_bundle(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b0);
        cycle();
        chk("imm_2048", out_instr, RC ? 32'h0000_0013 : 32'h8000_0013);
        chk("imm_2048_err", {31'd0, err}, {31'd0, RC});
        set_bundle(2'd3, 5'd4, 5'd4, 5'd4, 3'd4, 32'd4, 1'b0);
        cycle();
        chk("rsvd_nop", out_instr, 32'h0000_0013);
        chk("rsvd_err", {31'd0, err}, 32'd1);
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Run control: five words, reject in the middle, last on the fifth.
        pulse_start();
        chk("start_clr_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_random(1'b0);
            if (i == 2)
                in_fmt = 2'd3;
            in_last = (i == 4);
            cycle();
            if (i == 0)
                chk("run_first_addr", 32'(out_addr), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("done_before_xfer", {31'd0, done}, 32'd0);
        cycle();
        chk("done_rise", {31'd0, done}, 32'd1);
        chk("done_out_valid", {31'd0, out_valid}, 32'd0);
        set_random(1'b0);
        cycle();
        cycle();
        in_valid = 1'b0;
        pulse_start();
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_err", {31'd0, err}, 32'd0);

        // Start coincident with the last word's handshake.
        set_random(1'b0);
        in_last = 1'b1;
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        pulse_start();
        chk("start_on_last_done", {31'd0, done}, 32'd0);

        // Address wrap with ADDR_W = 4.
        for (int i = 0; i < 17; i++) begin
            set_random(1'b0);
            cycle();
            if (i == 15)
                chk("wrap_addr15", 32'(out_addr), 32'd15);
        end
        chk("wrap_addr0", 32'(out_addr), 32'd0);
        in_valid = 1'b0;
        cycle();

        // Start while a word is pending drops it.
        set_random(1'b0);
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pulse_start();
        chk("start_drop", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            set_random(1'b1);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

        // Reset mid-run with a word pending.
        set_random(1'b0);
        cycle();
        out_ready = 1'b0;
        set_random(1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_instr", out_instr, 32'h0);
        chk("midrst_addr", 32'(out_addr), 32'h0);
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("midrst_no_accept", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        pulse_start();
        set_random(1'b0);
        cycle();
        chk("after_rst_addr", 32'(out_addr), 32'd0);
        in_valid = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Assembles 32-bit RV32I instruction words from decoded fields (format, rd, rs1, rs2, funct3, full 32-bit immediate) for the I-ALU, LOAD and STORE formats the core's immediate generator decodes. It sits between the test/program-loader front end and instruction memory. It accepts one field bundle per handshake, emits one registered instruction word plus its word address, and tracks a program run from `start` to the last word.

## Interface
- `ADDR_W`, 10: width of the word-address counter.
- `BASE_ADDR`, 0: word address loaded on `start` and at reset.
---
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle pulse that begins a run.
- `in_valid` in 1: field bundle is valid.
- `in_ready` out 1: encoder can accept the bundle.
- `in_fmt` in 2: 0 = I-ALU (0010011), 1 = LOAD (0000011), 2 = STORE (0100011), 3 = reserved.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_funct3` in 3: funct3 field.
- `in_imm` in 32: sign-extended immediate value.
- `in_last` in 1: this bundle is the final word of the run.
- `out_valid` out 1: `out_instr` and `out_addr` are valid.
- `out_ready` in 1: downstream accepts the word.
- `out_instr` out 32: encoded instruction.
- `out_addr` out ADDR_W: word address of `out_instr`.
- `done` out 1: run complete; stays high until the next `start`.
- `err` out 1: sticky; at least one bundle in this run was rejected.

## Operation
- FSM states and transitions:
  - IDLE: `start` moves to RUN.
  - RUN: the handshake of an output word flagged last moves to DONE.
  - DONE: `start` moves to RUN.
  - `start` in any state restarts the run: FSM goes to RUN, address counter reloads to `BASE_ADDR`, `err` and `done` clear, and any pending output word is dropped (`out_valid` goes to 0).
- Encoding:
  - I-ALU and LOAD: {imm[11:0], rs1, funct3, rd, opcode}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - `in_rs2` is ignored for I-ALU and LOAD. `in_rd` is ignored for STORE.
- Rejected bundles:
  - A bundle is rejected if `in_fmt` = 3, or (with the range check, see Configuration) if the immediate does not fit a signed 12-bit field.
  - A rejected bundle is still emitted as a word, so the address sequence stays dense.
  - The emitted word is NOP 0x00000013, and `err` is set.
- Address counter:
  - Each accepted bundle takes the current address for its output word; the counter then increments by 1.
  - The counter wraps modulo 2^ADDR_W without a flag.
- One-entry output register with a pass-through handshake:
  - `in_ready` = (state == RUN) && !start && (!out_valid || out_ready).
  - Input is accepted when `in_valid && in_ready`.
  - Output transfers when `out_valid && out_ready`.
  - Accept and transfer in the same cycle: the register reloads with the new word and `out_valid` stays 1.
- Bundles presented in IDLE or DONE are not accepted (`in_ready` = 0). They do not change state.

## Timing
- Latency: the word appears on `out_*` the cycle after acceptance, so throughput is 1 word/cycle when `out_ready` = 1.
- While `out_valid` = 1 and `out_ready` = 0, `out_instr` and `out_addr` hold stable.
- `done` rises the cycle after the last word transfers. `out_valid` is 0 at that point unless a restart has already begun.
- Reset values: state IDLE, `out_valid` 0, `out_instr` 0, `out_addr` = `BASE_ADDR`, counter = `BASE_ADDR`, `done` 0, `err` 0. Because `in_ready` depends on state, it is 0 after reset.
- `start` coincident with `in_valid`: `start` wins and the bundle is not accepted.
- `start` coincident with the last word's output handshake: the word transfers, and the FSM ends in RUN with `done` = 0.

## Configuration
- `IMM_RANGE_CHECK_EN` defined: a bundle whose `in_imm` is outside [-2048, 2047] (bits 31:11 not all equal) is rejected. It is emitted as NOP and sets `err`.
- `IMM_RANGE_CHECK_EN` undefined: `in_imm[11:0]` is used without a check. Only `in_fmt` = 3 sets `err`.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants OP_IMM, OP_LOAD, OP_STORE;
  - the 2-bit format enum;
  - NOP constant 0x00000013;
  - the FSM state typedef.
- One combinational sub-module, `instr_pack`, maps fields to the instruction word and the reject flag. The top level holds the FSM, the counter and the output register.

## Test plan
- Field encoding, `out_ready` held 1 (BASE_ADDR = 0):
  - After `start`, I-ALU rd=1 rs1=2 f3=0 imm=0xFFFFFFFF → `out_instr` 0xFFF10093, `out_addr` 0, one cycle later.
  - LOAD rd=5 rs1=6 f3=2 imm=8 → 0x00832283 at addr 1.
  - STORE rs2=7 rs1=8 f3=2 imm=20 → 0x00742A23 at addr 2.
- Backpressure: `out_ready` = 0 for 3 cycles with `in_valid` held → `in_ready` = 0, and the word and address stay stable. When `out_ready` = 1, words resume back-to-back with no loss or duplication.
- Reject path:
  - With the macro: imm=2048 → 0x00000013, `err` = 1 sticky.
  - `in_fmt` = 3 → NOP and `err` in both builds.
  - Without the macro: I-ALU rd=0 rs1=0 f3=0 imm=2048 → 0x80000013, `err` stays 0.
- Run control: five bundles with `in_last` on the fifth → `done` rises the cycle after the fifth word transfers. A new `start` clears `done` and `err` and reloads the address to `BASE_ADDR`.
- Wrap and restart: ADDR_W = 4, 17 words → the last address is 0 after 15.
  - `start` while a word is pending drops it (`out_valid` 0 the next cycle).
  - `rst` mid-run restores all reset values and holds `in_ready` at 0 until `start`.
